// File: rtl/clock_pkg.sv
// Shared constants, hold codes and hold decode for the clock chain.
// Reused by the second, minute and hour stages.
package clock_pkg;

  localparam int MIN_MAX  = 59;
  localparam int HOUR_MAX = 23;
  localparam int HOUR_W   = 5;
  localparam int MIN_W    = 6;

  localparam logic [2:0] HOLD_RUN      = 3'b000;
  localparam logic [2:0] HOLD_SET_HOUR = 3'b100;
  localparam logic [2:0] HOLD_FRZ_001  = 3'b001;
  localparam logic [2:0] HOLD_FRZ_010  = 3'b010;
  localparam logic [2:0] HOLD_FRZ_011  = 3'b011;
  localparam logic [2:0] HOLD_FRZ_101  = 3'b101;
  localparam logic [2:0] HOLD_FRZ_110  = 3'b110;
  localparam logic [2:0] HOLD_FRZ_111  = 3'b111;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_SET_HOUR,
    ST_FREEZE
  } hold_st_e;

  function automatic hold_st_e decode_hold(input logic [2:0] h);
    hold_st_e st;
    st = ST_FREEZE;
    case (h)
      HOLD_RUN:      st = ST_RUN;
      HOLD_SET_HOUR: st = ST_SET_HOUR;
      HOLD_FRZ_001,
      HOLD_FRZ_010,
      HOLD_FRZ_011,
      HOLD_FRZ_101,
      HOLD_FRZ_110,
      HOLD_FRZ_111:  st = ST_FREEZE;
      default:       st = ST_FREEZE;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/hour_fmt.sv
// Formats an internal 0..23 hour for 24h or 12h display, plus PM flag.
// Purely combinational so the alarm-compare block can share it.
module hour_fmt
  import clock_pkg::*;
(
  input  logic [HOUR_W-1:0] cnt,
  input  logic              mode_24h,
  output logic [HOUR_W-1:0] hour,
  output logic              pm
);

  localparam logic [HOUR_W-1:0] HALF = HOUR_W'(12);

  always_comb begin
    pm   = (cnt >= HALF);
    hour = cnt;
    if (!mode_24h) begin
      if (cnt == '0)
        hour = HALF;
      else if (cnt > HALF)
        hour = cnt - HALF;
    end
  end

endmodule

// File: rtl/min_to_hour_counter.sv
// Hour stage: detects minute rollover, counts 0..23 under hold control,
// and registers the formatted hour, PM flag and day rollover pulse.
module min_to_hour_counter
  import clock_pkg::*;
#(
  parameter int unsigned RESET_HOUR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [MIN_W-1:0]  min,
  input  logic [2:0]        hold,
  input  logic              mode_24h,
  output logic [HOUR_W-1:0] hour,
  output logic              pm,
  output logic              day_tick
);

  localparam logic [HOUR_W-1:0] H_MAX = HOUR_W'(HOUR_MAX);
  localparam logic [MIN_W-1:0]  M_MAX = MIN_W'(MIN_MAX);

  logic [HOUR_W-1:0] hour_cnt;
  logic [HOUR_W-1:0] hour_nxt;
  logic [HOUR_W-1:0] hour_inc;
  logic [HOUR_W-1:0] fmt_hour;
  logic [MIN_W-1:0]  min_prev;
  logic [2:0]        hold_q;
  logic              fmt_pm;
  logic              carry;
  logic              tick_nxt;
  hold_st_e          st;

  // Both the current and previous hold must be RUN, so set edits never carry.
  assign carry = (min_prev == M_MAX) && (min == '0)
              && (hold == HOLD_RUN) && (hold_q == HOLD_RUN);

  assign st       = decode_hold(hold);
  assign hour_inc = (hour_cnt == H_MAX) ? '0 : hour_cnt + 1'b1;

  always_comb begin
    hour_nxt = hour_cnt;
    tick_nxt = 1'b0;
    unique case (1'b1)
      (st == ST_RUN): begin
        if (carry) begin
          hour_nxt = hour_inc;
          tick_nxt = (hour_cnt == H_MAX);
        end
      end
      (st == ST_SET_HOUR): hour_nxt = hour_inc;
      default: hour_nxt = hour_cnt;
    endcase
  end

  hour_fmt u_fmt (
    .cnt      (hour_nxt),
    .mode_24h (mode_24h),
    .hour     (fmt_hour),
    .pm       (fmt_pm)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hour_cnt <= HOUR_W'(RESET_HOUR);
      min_prev <= '0;
      hold_q   <= HOLD_RUN;
      hour     <= '0;
      pm       <= 1'b0;
      day_tick <= 1'b0;
    end else begin
      hour_cnt <= hour_nxt;
      min_prev <= min;
      hold_q   <= hold;
      hour     <= fmt_hour;
      pm       <= fmt_pm;
      day_tick <= tick_nxt;
    end
  end

endmodule

// File: tb/tb_min_to_hour_counter.sv
// Self-checking bench for min_to_hour_counter: directed scenarios plus
// randomized traffic against a behavioural hour-of-day model.
module tb_min_to_hour_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] min;
  logic [2:0] hold;
  logic       mode_24h;
  logic [4:0] hour;
  logic       pm;
  logic       day_tick;

  int checks = 0;
  int errors = 0;

  // model state
  int m_cnt;
  int m_prev_min;
  int m_prev_hold;
  int exp_hour;
  int exp_pm;
  int exp_tick;

  always #5 clk = ~clk;

  min_to_hour_counter #(.RESET_HOUR(0)) dut (
    .clk      (clk),
    .rst      (rst),
    .min      (min),
    .hold     (hold),
    .mode_24h (mode_24h),
    .hour     (hour),
    .pm       (pm),
    .day_tick (day_tick)
  );

  function automatic int disp(input int h, input bit m24);
    if (m24) return h;
    return (h % 12 == 0) ? 12 : h % 12;
  endfunction

  task automatic step(input int mn, input int hd, input bit m24);
    bit c;
    min      = 6'(mn);
    hold     = 3'(hd);
    mode_24h = m24;
    @(posedge clk);
    c = (m_prev_min == 59) && (mn == 0) && (hd == 0) && (m_prev_hold == 0);
    exp_tick = 0;
    if (hd == 0 && c) begin
      exp_tick = (m_cnt == 23);
      m_cnt = (m_cnt + 1) % 24;
    end else if (hd == 4) begin
      m_cnt = (m_cnt + 1) % 24;
    end
    m_prev_min  = mn;
    m_prev_hold = hd;
    exp_hour = disp(m_cnt, m24);
    exp_pm   = (m_cnt >= 12);
    #1;
  endtask

  task automatic set_hour(input int target, input bit m24);
    int guard = 0;
    while (m_cnt != target && guard < 30) begin
      step(30, 4, m24);
      guard++;
    end
    step(0, 0, m24);
  endtask

  task automatic test_reset;
    rst = 1'b1; min = 0; hold = 0; mode_24h = 1'b1;
    m_cnt = 0; m_prev_min = 0; m_prev_hold = 0;
    #12;
    checks++;
    if (hour !== 5'd0 || pm !== 1'b0 || day_tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_during: hour=%0d pm=%0b tick=%0b required 0/0/0",
               hour, pm, day_tick);
    end
    @(negedge clk);
    rst = 1'b0;
    step(0, 0, 1'b1);
    checks++;
    if (hour !== 5'd0 || pm !== 1'b0 || day_tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_after: hour=%0d pm=%0b tick=%0b required 0/0/0",
               hour, pm, day_tick);
    end
  endtask

  task automatic test_carry;
    int mins[3] = '{58, 59, 0};
    int want[3] = '{9, 9, 10};
    set_hour(9, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(mins[i], 0, 1'b1);
      checks++;
      if (hour !== 5'(want[i]) || day_tick !== 1'b0) begin
        errors++;
        $display("FAIL carry_%0d: hour=%0d tick=%0b required %0d/0",
                 i, hour, day_tick, want[i]);
      end
    end
  endtask

  task automatic test_day_wrap;
    set_hour(23, 1'b1);
    step(58, 0, 1'b1);
    step(59, 0, 1'b1);
    step(0, 0, 1'b1);
    checks++;
    if (hour !== 5'd0 || pm !== 1'b0 || day_tick !== 1'b1) begin
      errors++;
      $display("FAIL day_wrap: hour=%0d pm=%0b tick=%0b required 0/0/1",
               hour, pm, day_tick);
    end
    step(1, 0, 1'b1);
    checks++;
    if (day_tick !== 1'b0 || hour !== 5'd0) begin
      errors++;
      $display("FAIL day_tick_pulse: hour=%0d tick=%0b required 0/0",
               hour, day_tick);
    end
  endtask

  task automatic test_freeze_no_carry;
    set_hour(5, 1'b1);
    step(59, 0, 1'b1);
    step(0, 1, 1'b1);
    checks++;
    if (hour !== 5'd5 || day_tick !== 1'b0) begin
      errors++;
      $display("FAIL freeze_edit: hour=%0d tick=%0b required 5/0",
               hour, day_tick);
    end
    step(0, 0, 1'b1);
    checks++;
    if (hour !== 5'd5 || day_tick !== 1'b0) begin
      errors++;
      $display("FAIL freeze_release: hour=%0d tick=%0b required 5/0",
               hour, day_tick);
    end
    step(59, 2, 1'b1);
    step(0, 0, 1'b1);
    checks++;
    if (hour !== 5'd5) begin
      errors++;
      $display("FAIL freeze_prev_hold: hour=%0d required 5", hour);
    end
  endtask

  task automatic test_set_hour;
    int want;
    set_hour(22, 1'b1);
    for (int k = 1; k <= 26; k++) begin
      step(59, 4, 1'b1);
      want = (22 + k) % 24;
      checks++;
      if (hour !== 5'(want) || day_tick !== 1'b0) begin
        errors++;
        $display("FAIL set_hour_%0d: hour=%0d tick=%0b required %0d/0",
                 k, hour, day_tick, want);
      end
    end
  endtask

  task automatic test_12h;
    int ints[5] = '{0, 11, 12, 13, 23};
    int dh[5]   = '{12, 11, 12, 1, 11};
    int dp[5]   = '{0, 0, 1, 1, 1};
    for (int i = 0; i < 5; i++) begin
      set_hour(ints[i], 1'b0);
      checks++;
      if (hour !== 5'(dh[i]) || pm !== dp[i][0]) begin
        errors++;
        $display("FAIL fmt12_%0d: hour=%0d pm=%0b required %0d/%0d",
                 ints[i], hour, pm, dh[i], dp[i]);
      end
    end
    set_hour(13, 1'b0);
    step(0, 0, 1'b1);
    checks++;
    if (hour !== 5'd13 || pm !== 1'b1) begin
      errors++;
      $display("FAIL mode_toggle: hour=%0d pm=%0b required 13/1", hour, pm);
    end
  endtask

  task automatic test_random;
    int mn, hd;
    bit m24;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: mn = 59;
        1: mn = 0;
        default: mn = $urandom_range(0, 63);
      endcase
      case ($urandom_range(0, 7))
        0: hd = 4;
        1: hd = $urandom_range(0, 7);
        default: hd = 0;
      endcase
      m24 = ($urandom_range(0, 3) != 0);
      step(mn, hd, m24);
      checks++;
      if (hour !== 5'(exp_hour) || pm !== exp_pm[0]
          || day_tick !== exp_tick[0]) begin
        errors++;
        $display("FAIL random_%0d: hour=%0d pm=%0b tick=%0b required %0d/%0d/%0d",
                 i, hour, pm, day_tick, exp_hour, exp_pm, exp_tick);
      end
    end
  endtask

  initial begin
    test_reset;
    test_carry;
    test_day_wrap;
    test_freeze_no_carry;
    test_set_hour;
    test_12h;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/min_to_hour_counter.md
Name: min_to_hour_counter

Overview:
- Downstream stage of the second-to-minute converter.
- Consumes the 6-bit minute value and the shared 3-bit hold bus.
- Detects the 59->0 minute rollover and advances an hour count held internally as 0..23.
- Drives the registered hour display in 24h or 12h format, a PM flag, and a one-cycle day-rollover pulse for a later calendar stage.

Parameters:
- RESET_HOUR, 0, internal hour value (0..23) loaded on reset; values above 23 are illegal.

Ports:
- clk  in  1  clock; rising edge. One edge per second, same clock as the minute stage.
- rst  in  1  asynchronous, active-high reset.
- min  in  6  minute value from the upstream minute stage, 0..59.
- hold  in  3  shared set/suspend control bus.
- mode_24h  in  1  1 = 24h display (0..23); 0 = 12h display (1..12).
- hour  out  5  registered display hour.
- pm  out  1  registered flag; 1 when internal hour is 12..23, in either mode.
- day_tick  out  1  registered, high for exactly one cycle when the internal hour wraps 23->0.

Behaviour:
- Reset (async, rst=1), all take effect immediately:
  - hour_cnt=RESET_HOUR, min_prev=0, hold_q=3'b000.
  - Outputs: hour=5'd0, pm=0, day_tick=0.
  - Display registers take formatted values on the first clock edge after rst deasserts.
  - Reset mid-set or mid-carry aborts the operation; no pending carry survives.
- Every edge: min_prev<=min and hold_q<=hold, regardless of hold value.
- carry = (min_prev==59) && (min==0) && (hold==3'b000) && (hold_q==3'b000).
  - Minute edits made in set modes never carry into hours, including the edit cycle and the release cycle.
- Hold decode, one state per class:
  - RUN (hold=000): on carry, hour_cnt <= (hour_cnt==23) ? 0 : hour_cnt+1.
  - SET_HOUR (hold=100): hour_cnt increments by 1 every edge, wrapping 23->0. day_tick is never asserted in this state.
  - FREEZE (hold=001,010,011,101,110,111): hour_cnt holds.
  - State is a pure decode of the current hold; no sticky state.
- day_tick <= carry && (hour_cnt==23), RUN state only.
- Display, computed from the next-state hour_cnt so the display updates on the same edge as the count (1-clock latency from min==0 sampled):
  - 24h mode: hour = hour_cnt.
  - 12h mode: internal 0 -> 12; internal 1..12 -> same value; internal 13..23 -> value-12.
  - pm = (hour_cnt>=12) in both modes.
- mode_24h toggling: internal count unaffected; display reformats on the next edge.
- Illegal min input (60..63): treated as a non-zero, non-59 value; never produces a carry; stored into min_prev normally.
- All arithmetic 5-bit unsigned; no value outside 0..23 is reachable internally.

Decomposition:
- Shared package clock_pkg:
  - Constants MIN_MAX=59, HOUR_MAX=23, HOUR_W=5, MIN_W=6.
  - Hold code localparams: HOLD_RUN=000, HOLD_SET_HOUR=100, plus the FREEZE code list.
  - Reused by the minute and second stages.
- One combinational sub-module, hour_fmt: hour_cnt[4:0] + mode_24h -> {hour[4:0], pm}. Reusable by the alarm-compare block.
- Counter, edge detection and hold decode stay in min_to_hour_counter.

Test Plan:
1. Reset with RESET_HOUR=0, mode_24h=1, min held at 0 -> hour=0, pm=0, day_tick=0 during reset and after the first edge.
2. hour_cnt=9, hold=000; drive min 58,59,0 on successive edges -> hour=10 on the edge sampling min=0. No change on other edges.
3. hour_cnt=23, hold=000; min 59->0 -> hour=0, pm=0, day_tick=1 for one cycle, then 0.
4. hold=001 while min forced 59->0, then hold=000 with min=0 -> no hour change, day_tick=0 throughout.
5. hold=100 for 26 edges starting at hour_cnt=22 -> count sequence 23,0,1,...,23,0. day_tick stays 0 across the 23->0 wrap.
6. mode_24h=0 sweep over internal 0,11,12,13,23 -> hour/pm = 12/0, 11/0, 12/1, 1/1, 11/1. Toggling mode_24h to 1 at internal 13 -> hour=13, pm=1 on the next edge.
